// File: rtl/lcd_char_writer.sv
// lcd_char_writer: power-on init plus character/clear writes to an 8-bit HD44780-style LCD.
// Define LCD_LINE_WRAP_EN for two-line wrapping (0xC0 at column 16, 0x80 at column 32).
module lcd_char_writer #(
  parameter int PWR_DLY = 750000,
  parameter int E_CYC   = 25,
  parameter int CMD_DLY = 2500,
  parameter int CLR_DLY = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_char,
  input  logic       i_char_vld,
  input  logic       i_clr,
  output logic       o_ready,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);
  localparam int MAX_A = PWR_DLY > CLR_DLY ? PWR_DLY : CLR_DLY;
  localparam int MAX_B = CMD_DLY > E_CYC ? CMD_DLY : E_CYC;
  localparam int MAX_D = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int CW = $clog2(MAX_D + 1);
  localparam logic [CW-1:0] PWR_END = CW'(PWR_DLY - 1);
  localparam logic [CW-1:0] E_END   = CW'(E_CYC - 1);
  localparam logic [CW-1:0] CMD_END = CW'(CMD_DLY - 1);
  localparam logic [CW-1:0] CLR_END = CW'(CLR_DLY - 1);
  localparam logic [1:0] K_INIT = 2'd0, K_CHAR = 2'd1, K_CMD = 2'd2;

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, EHIGH, WAIT, NEWLINE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [4:0]      r_col, w_col_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [1:0]      r_kind, w_kind_nxt;
  logic            r_rs, w_rs_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic [7:0]      w_init_cmd, w_nl_cmd;
  logic [CW-1:0]   w_dly_end;
  logic            w_line_end;

  assign w_init_cmd = r_idx == 2'd0 ? 8'h38 : r_idx == 2'd1 ? 8'h0C : r_idx == 2'd2 ? 8'h06 : 8'h01;
  assign w_dly_end  = (!r_rs && r_data == 8'h01) ? CLR_END : CMD_END;

  // line_end is judged on the column before the increment of the finishing character
`ifdef LCD_LINE_WRAP_EN
  assign w_line_end = r_col == 5'd15 || r_col == 5'd31;
  assign w_nl_cmd   = r_col == 5'd16 ? 8'hC0 : 8'h80;
`else
  assign w_line_end = r_col == 5'd15;
  assign w_nl_cmd   = 8'h80;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col;
    w_idx_nxt   = r_idx;
    w_kind_nxt  = r_kind;
    w_rs_nxt    = r_rs;
    w_data_nxt  = r_data;
    case (r_state)
      PWR_WAIT: begin
        w_cnt_nxt   = r_cnt == PWR_END ? '0 : r_cnt + 1'b1;
        w_state_nxt = r_cnt == PWR_END ? INIT : PWR_WAIT;
      end
      INIT: begin
        w_state_nxt = SETUP;
        w_rs_nxt    = 1'b0;
        w_data_nxt  = w_init_cmd;
        w_kind_nxt  = K_INIT;
      end
      IDLE: begin
        if (i_clr) begin
          w_state_nxt = SETUP;
          w_rs_nxt    = 1'b0;
          w_data_nxt  = 8'h01;
          w_kind_nxt  = K_CMD;
          w_col_nxt   = '0;
        end else if (i_char_vld) begin
          w_state_nxt = SETUP;
          w_rs_nxt    = 1'b1;
          w_data_nxt  = i_char;
          w_kind_nxt  = K_CHAR;
        end
      end
      SETUP: w_state_nxt = EHIGH;
      EHIGH: begin
        w_cnt_nxt   = r_cnt == E_END ? '0 : r_cnt + 1'b1;
        w_state_nxt = r_cnt == E_END ? WAIT : EHIGH;
      end
      WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == w_dly_end) begin
          w_cnt_nxt = '0;
          if (r_kind == K_INIT) begin
            w_state_nxt = r_idx == 2'd3 ? IDLE : INIT;
            w_idx_nxt   = r_idx + 1'b1;
            w_col_nxt   = '0;
          end else if (r_kind == K_CHAR) begin
            w_state_nxt = w_line_end ? NEWLINE : IDLE;
            w_col_nxt   = r_col + 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      NEWLINE: begin
        w_state_nxt = SETUP;
        w_rs_nxt    = 1'b0;
        w_data_nxt  = w_nl_cmd;
        w_kind_nxt  = K_CMD;
        w_col_nxt   = w_nl_cmd == 8'h80 ? '0 : r_col;
      end
      default: w_state_nxt = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= PWR_WAIT;
      r_cnt   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
      r_kind  <= K_INIT;
      r_rs    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_col   <= w_col_nxt;
      r_idx   <= w_idx_nxt;
      r_kind  <= w_kind_nxt;
      r_rs    <= w_rs_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // decoded straight from the state so reset removes the enable without waiting for a clock
  assign lcd_e    = r_state == EHIGH;
  assign o_ready  = r_state == IDLE;
  assign lcd_rs   = r_rs;
  assign lcd_data = r_data;
  assign lcd_rw   = 1'b0;
endmodule
